// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package rv_mem_pkg;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/rv_src_fifo.sv
// In-order record of which source owns each outstanding memory request.
module rv_src_fifo #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          push_src,
  input  logic          pop,
  output logic          head_src,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] slots;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_src = slots[rd_ptr];

  // Slot contents need no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_src;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter merging fetch and load/store requests onto one memory
// port, with zero-cycle forwarding and in-order response routing.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req_valid,
  output logic        instr_req_ready,
  input  logic [31:0] instr_req_addr,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_data,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic        data_req_wr,
  input  logic [1:0]  data_req_size,
  input  logic [31:0] data_req_addr,
  input  logic [31:0] data_req_data,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wr,
  output logic [1:0]  mem_req_size,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        rsp_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  arb_state_t    state, state_n;
  src_t          last_gnt;
  src_t          gnt;
  logic          has_gnt;
  logic          src_valid;
  logic          slot_avail;
  logic          hs;
  logic          rsp_pop;
  logic          head_src;
  logic [CW-1:0] count;

  // A response arriving this cycle frees a slot, so a full FIFO can still accept.
  assign slot_avail = (count < DEPTH_C) || mem_rsp_valid;

  always_comb begin
    has_gnt = 1'b0;
    gnt     = SRC_I;
    state_n = state;
    unique case (state)
      IDLE: begin
        if (slot_avail) begin
          if (instr_req_valid && data_req_valid) begin
            has_gnt = 1'b1;
            gnt     = (last_gnt == SRC_I) ? SRC_D : SRC_I;
          end else if (instr_req_valid) begin
            has_gnt = 1'b1;
            gnt     = SRC_I;
          end else if (data_req_valid) begin
            has_gnt = 1'b1;
            gnt     = SRC_D;
          end
        end
      end
      LOCK_I: begin
        has_gnt = slot_avail;
        gnt     = SRC_I;
      end
      LOCK_D: begin
        has_gnt = slot_avail;
        gnt     = SRC_D;
      end
      default: ;
    endcase
    if (!reset_n) has_gnt = 1'b0;

    src_valid = (gnt == SRC_I) ? instr_req_valid : data_req_valid;
    hs        = has_gnt && src_valid && mem_req_ready;

    // A locked source that drops valid keeps its lock until it completes.
    if (hs) begin
      state_n = IDLE;
    end else if (has_gnt && src_valid) begin
      state_n = (gnt == SRC_I) ? LOCK_I : LOCK_D;
    end
  end

  always_comb begin
    mem_req_valid   = has_gnt && src_valid;
    mem_req_wr      = 1'b0;
    mem_req_size    = 2'b00;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    instr_req_ready = 1'b0;
    data_req_ready  = 1'b0;
    if (has_gnt) begin
      if (gnt == SRC_I) begin
        mem_req_size    = SIZE_WORD;
        mem_req_addr    = instr_req_addr;
        instr_req_ready = mem_req_ready && slot_avail;
      end else begin
        mem_req_wr     = data_req_wr;
        mem_req_size   = data_req_size;
        mem_req_addr   = data_req_addr;
        mem_req_data   = data_req_data;
        data_req_ready = mem_req_ready && slot_avail;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_gnt <= SRC_I;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (hs) last_gnt <= gnt;
      if (mem_rsp_valid && (count == '0)) rsp_err <= 1'b1;
    end
  end

  assign rsp_pop         = reset_n && mem_rsp_valid && (count != '0);
  assign instr_rsp_valid = rsp_pop && (head_src == SRC_I);
  assign data_rsp_valid  = rsp_pop && (head_src == SRC_D);
  assign instr_rsp_data  = mem_rsp_data;
  assign data_rsp_data   = mem_rsp_data;

  rv_src_fifo #(
    .DEPTH(DEPTH)
  ) u_order (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (hs),
    .push_src (gnt),
    .pop      (rsp_pop),
    .head_src (head_src),
    .count    (count)
  );

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_rv_mem_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req_valid, instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;
  logic        data_req_valid, data_req_ready, data_req_wr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_addr, data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wr;
  logic [1:0]  mem_req_size;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req_valid(instr_req_valid), .instr_req_ready(instr_req_ready),
    .instr_req_addr(instr_req_addr),
    .instr_rsp_valid(instr_rsp_valid), .instr_rsp_data(instr_rsp_data),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_wr(data_req_wr), .data_req_size(data_req_size),
    .data_req_addr(data_req_addr), .data_req_data(data_req_data),
    .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_size(mem_req_size),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rsp_err(rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    instr_req_valid = 1'b0; instr_req_addr = '0;
    data_req_valid  = 1'b0; data_req_wr = 1'b0; data_req_size = 2'b00;
    data_req_addr   = '0;   data_req_data = '0;
    mem_req_ready   = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic check_quiet(input string tag);
    chkb({tag, "_mem_v"}, mem_req_valid, 1'b0);
    chkb({tag, "_ir"}, instr_req_ready, 1'b0);
    chkb({tag, "_dr"}, data_req_ready, 1'b0);
    chk({tag, "_addr"}, mem_req_addr, 32'h0);
    chkb({tag, "_irv"}, instr_rsp_valid, 1'b0);
    chkb({tag, "_drv"}, data_rsp_valid, 1'b0);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic iv; logic [31:0] ia;
    logic dv; logic dwr; logic [1:0] dsz; logic [31:0] da; logic [31:0] dd;
    logic mrdy; logic rv; logic [31:0] rd;
    logic e_mv; logic [31:0] e_ma; logic e_mwr; logic [1:0] e_msz; logic [31:0] e_md;
    logic e_ir; logic e_dr; logic e_irv; logic e_drv; logic [31:0] e_rd; logic e_err;
  } vec_t;

  vec_t vt[11];

  // Reference model state
  int   q[$];
  int   last_g;
  int   lock_s;
  logic err_m;

  initial begin
    logic ipend, dpend;
    reset_n = 1'b1;
    clear_inputs();

    // iv ia dv dwr dsz da dd mrdy rv rd | e_mv e_ma e_mwr e_msz e_md e_ir e_dr e_irv e_drv e_rd e_err
    vt[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h100, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h13,
               1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13, 1'b0};
    vt[2]  = '{1'b1, 32'h200, 1'b1, 1'b0, 2'b01, 32'h300, 32'h12345678, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h300, 1'b0, 2'b01, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 32'h200, 1'b1, 1'b0, 2'b01, 32'h300, 32'h12345678, 1'b1, 1'b1, 32'h55,
               1'b1, 32'h200, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0};
    vt[4]  = '{1'b1, 32'h200, 1'b1, 1'b0, 2'b01, 32'h300, 32'h12345678, 1'b1, 1'b0, 32'h0,
               1'b1, 32'h300, 1'b0, 2'b01, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 32'h200, 1'b1, 1'b0, 2'b01, 32'h300, 32'h12345678, 1'b1, 1'b0, 32'h0,
               1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 32'h200, 1'b1, 1'b0, 2'b01, 32'h300, 32'h12345678, 1'b1, 1'b1, 32'hAA,
               1'b1, 32'h200, 1'b0, 2'b10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAA, 1'b0};
    vt[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hB1,
               1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB1, 1'b0};
    vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hB2,
               1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB2, 1'b0};
    vt[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hEE,
               1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[10] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};

    // Reset state, including outputs while reset is held with a requester active
    reset_n = 1'b0;
    instr_req_valid = 1'b1; instr_req_addr = 32'h44; mem_req_ready = 1'b1;
    #3;
    check_quiet("rst");
    chkb("rst_err", rsp_err, 1'b0);
    do_reset();

    for (int i = 0; i < 11; i++) begin
      instr_req_valid = vt[i].iv;  instr_req_addr = vt[i].ia;
      data_req_valid  = vt[i].dv;  data_req_wr = vt[i].dwr; data_req_size = vt[i].dsz;
      data_req_addr   = vt[i].da;  data_req_data = vt[i].dd;
      mem_req_ready   = vt[i].mrdy; mem_rsp_valid = vt[i].rv; mem_rsp_data = vt[i].rd;
      @(negedge clk);
      chkb($sformatf("v%0d_mem_v", i), mem_req_valid, vt[i].e_mv);
      chk($sformatf("v%0d_addr", i), mem_req_addr, vt[i].e_ma);
      chkb($sformatf("v%0d_wr", i), mem_req_wr, vt[i].e_mwr);
      chk($sformatf("v%0d_size", i), 32'(mem_req_size), 32'(vt[i].e_msz));
      chk($sformatf("v%0d_wdata", i), mem_req_data, vt[i].e_md);
      chkb($sformatf("v%0d_ir", i), instr_req_ready, vt[i].e_ir);
      chkb($sformatf("v%0d_dr", i), data_req_ready, vt[i].e_dr);
      chkb($sformatf("v%0d_irv", i), instr_rsp_valid, vt[i].e_irv);
      chkb($sformatf("v%0d_drv", i), data_rsp_valid, vt[i].e_drv);
      if (vt[i].e_irv) chk($sformatf("v%0d_irdata", i), instr_rsp_data, vt[i].e_rd);
      if (vt[i].e_drv) chk($sformatf("v%0d_drdata", i), data_rsp_data, vt[i].e_rd);
      chkb($sformatf("v%0d_err", i), rsp_err, vt[i].e_err);
      next_cycle();
    end

    // Store stalled by memory for three cycles while fetch waits
    do_reset();
    data_req_valid = 1'b1; data_req_wr = 1'b1; data_req_size = 2'b00;
    data_req_addr = 32'h20; data_req_data = 32'hDEADBEEF;
    instr_req_valid = 1'b1; instr_req_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = (k == 3);
      @(negedge clk);
      chkb($sformatf("st%0d_mem_v", k), mem_req_valid, 1'b1);
      chk($sformatf("st%0d_addr", k), mem_req_addr, 32'h20);
      chkb($sformatf("st%0d_wr", k), mem_req_wr, 1'b1);
      chk($sformatf("st%0d_wdata", k), mem_req_data, 32'hDEADBEEF);
      chkb($sformatf("st%0d_ir", k), instr_req_ready, 1'b0);
      chkb($sformatf("st%0d_dr", k), data_req_ready, k == 3);
      next_cycle();
    end
    data_req_valid = 1'b0;
    @(negedge clk);
    chk("st_fetch_addr", mem_req_addr, 32'h400);
    chkb("st_fetch_ir", instr_req_ready, 1'b1);
    next_cycle();
    instr_req_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77;
    @(negedge clk);
    chkb("st_ack_drv", data_rsp_valid, 1'b1);
    chkb("st_ack_irv", instr_rsp_valid, 1'b0);
    chk("st_ack_data", data_rsp_data, 32'h77);
    next_cycle();
    mem_rsp_data = 32'h88;
    @(negedge clk);
    chkb("st_fetch_irv", instr_rsp_valid, 1'b1);
    chk("st_fetch_data", instr_rsp_data, 32'h88);
    next_cycle();

    // Locked fetch that drops valid keeps the lock against a data request
    mem_rsp_valid = 1'b0;
    instr_req_valid = 1'b1; instr_req_addr = 32'h500; mem_req_ready = 1'b0;
    next_cycle();
    instr_req_valid = 1'b0; data_req_valid = 1'b1; data_req_addr = 32'h600; mem_req_ready = 1'b1;
    @(negedge clk);
    chkb("lock_mem_v", mem_req_valid, 1'b0);
    chkb("lock_dr", data_req_ready, 1'b0);
    next_cycle();
    instr_req_valid = 1'b1;
    @(negedge clk);
    chk("lock_addr", mem_req_addr, 32'h500);
    chkb("lock_ir", instr_req_ready, 1'b1);
    next_cycle();
    instr_req_valid = 1'b0; data_req_valid = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h99;
    next_cycle();

    // Orphan response sets the sticky error; a reset pulse clears it
    mem_rsp_data = 32'h5A;
    @(negedge clk);
    chkb("orph_irv", instr_rsp_valid, 1'b0);
    chkb("orph_drv", data_rsp_valid, 1'b0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chkb("orph_err", rsp_err, 1'b1);
    next_cycle();
    reset_n = 1'b0;
    #2 chkb("pulse_err", rsp_err, 1'b0);
    reset_n = 1'b1;
    next_cycle();

    // Reset with two outstanding requests: later responses are orphans
    instr_req_valid = 1'b1; instr_req_addr = 32'h700; mem_req_ready = 1'b1;
    next_cycle();
    instr_req_valid = 1'b0; data_req_valid = 1'b1; data_req_addr = 32'h704;
    next_cycle();
    data_req_valid = 1'b0; instr_req_valid = 1'b1;
    reset_n = 1'b0;
    #2;
    check_quiet("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    instr_req_valid = 1'b0; mem_req_ready = 1'b0;
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chkb($sformatf("mid_rsp%0d_irv", k), instr_rsp_valid, 1'b0);
      chkb($sformatf("mid_rsp%0d_drv", k), data_rsp_valid, 1'b0);
      next_cycle();
    end
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chkb("mid_err", rsp_err, 1'b1);

    // Randomized traffic against the queue-based model
    do_reset();
    q.delete(); last_g = 0; lock_s = -1; err_m = 1'b0;
    ipend = 1'b0; dpend = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      int   g;
      logic slot, e_mv, e_ir, e_dr, e_irv, e_drv, e_wr;
      logic [1:0]  e_sz;
      logic [31:0] e_ad, e_wd;
      if (!ipend) begin
        ipend = ($urandom_range(0, 2) != 0);
        instr_req_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dpend) begin
        dpend = ($urandom_range(0, 2) != 0);
        data_req_wr   = $urandom_range(0, 1) == 1;
        data_req_size = 2'($urandom_range(0, 2));
        data_req_addr = $urandom;
        data_req_data = $urandom;
      end
      instr_req_valid = ipend;
      data_req_valid  = dpend;
      mem_req_ready   = ($urandom_range(0, 3) != 0);
      mem_rsp_valid   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rsp_data    = $urandom;

      @(negedge clk);
      slot = (q.size() < DEPTH) || mem_rsp_valid;
      g = -1;
      if (slot) begin
        if (lock_s >= 0) g = lock_s;
        else if (instr_req_valid && data_req_valid) g = (last_g == 0) ? 1 : 0;
        else if (instr_req_valid) g = 0;
        else if (data_req_valid) g = 1;
      end
      e_mv  = (g == 0 && instr_req_valid) || (g == 1 && data_req_valid);
      e_ad  = (g == 0) ? instr_req_addr : (g == 1) ? data_req_addr : 32'h0;
      e_wd  = (g == 1) ? data_req_data : 32'h0;
      e_wr  = (g == 1) && data_req_wr;
      e_sz  = (g == 0) ? 2'b10 : (g == 1) ? data_req_size : 2'b00;
      e_ir  = (g == 0) && mem_req_ready;
      e_dr  = (g == 1) && mem_req_ready;
      e_irv = mem_rsp_valid && (q.size() > 0) && (q[0] == 0);
      e_drv = mem_rsp_valid && (q.size() > 0) && (q[0] == 1);

      chkb("rnd_mem_v", mem_req_valid, e_mv);
      chk("rnd_addr", mem_req_addr, e_ad);
      chk("rnd_wdata", mem_req_data, e_wd);
      chkb("rnd_wr", mem_req_wr, e_wr);
      chk("rnd_size", 32'(mem_req_size), 32'(e_sz));
      chkb("rnd_ir", instr_req_ready, e_ir);
      chkb("rnd_dr", data_req_ready, e_dr);
      chkb("rnd_irv", instr_rsp_valid, e_irv);
      chkb("rnd_drv", data_rsp_valid, e_drv);
      if (e_irv) chk("rnd_irdata", instr_rsp_data, mem_rsp_data);
      if (e_drv) chk("rnd_drdata", data_rsp_data, mem_rsp_data);
      chkb("rnd_err", rsp_err, err_m);

      if (mem_rsp_valid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (e_mv && mem_req_ready) begin
        q.push_back(g);
        last_g = g;
        lock_s = -1;
        if (g == 0) ipend = 1'b0;
        else dpend = 1'b0;
      end else if (e_mv) begin
        lock_s = g;
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv_mem_arbiter.md
RV_MEM_ARBITER -- requirements
Module: rv_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: max outstanding (accepted, unanswered) requests; legal 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr_req_valid/instr_req_ready  input/output  1/1  fetch request handshake.
REQ-005 instr_req_addr  input  32  fetch address.
REQ-006 instr_rsp_valid/instr_rsp_data  output  1/32  fetch response.
REQ-007 data_req_valid/data_req_ready  input/output  1/1  load/store request handshake.
REQ-008 data_req_wr, data_req_size, data_req_addr, data_req_data  input  1,2,32,32  store flag, size code, address, write data.
REQ-009 data_rsp_valid/data_rsp_data  output  1/32  load data or store ack.
REQ-010 mem_req_valid/mem_req_ready  output/input  1/1  shared memory request handshake.
REQ-011 mem_req_wr, mem_req_size, mem_req_addr, mem_req_data  output  1,2,32,32  forwarded request fields.
REQ-012 mem_rsp_valid/mem_rsp_data  input  1/32  memory response, in request order, no backpressure.
REQ-013 rsp_err  output  1  sticky: response arrived with no outstanding request.

Function
REQ-014 Every accepted mem request SHALL produce exactly one mem response, returned in acceptance order; stores included.
REQ-015 States IDLE, LOCK_I, LOCK_D; IDLE SHALL choose a source combinationally, LOCK_x SHALL hold that source.
REQ-016 IDLE, one requester valid: that source SHALL be granted; both valid: the source not granted last SHALL win (round-robin; last-grant = I after reset).
REQ-017 Granted source's valid and fields SHALL drive mem_req_* in the same cycle (zero-cycle forwarding); instr grants SHALL drive mem_req_wr=0, size=2'b10, data=0.
REQ-018 mem_req_valid high with mem_req_ready low SHALL enter LOCK_x; grant and all mem_req_* fields SHALL stay stable until handshake.
REQ-019 Handshake (mem_req_valid && mem_req_ready) SHALL return to IDLE, update last-grant, push source ID into the order FIFO.
REQ-020 Granted source's req_ready SHALL equal mem_req_ready AND slot_avail; non-granted ready SHALL be 0.
REQ-021 slot_avail SHALL be (count < DEPTH) OR mem_rsp_valid this cycle (simultaneous push and pop at full allowed).
REQ-022 slot_avail low SHALL force mem_req_valid=0; no grant; state unchanged.
REQ-023 mem_rsp_valid SHALL pop the FIFO head and raise instr_rsp_valid or data_rsp_valid in the same cycle, data passed unchanged; other rsp_valid 0.
REQ-024 mem_rsp_valid with count==0 SHALL set rsp_err, drop the response, leave count at 0.
REQ-025 count SHALL be $clog2(DEPTH+1) bits; push+pop same cycle leaves count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 LOCK_x SHALL hold even if the locked source drops valid (protocol violation); forwarded valid follows source.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, last-grant I, count 0, pointers 0, rsp_err 0.
REQ-028 Outputs during reset: all *_valid and *_ready 0; mem_req_* fields 0.
REQ-029 Reset mid-transaction SHALL discard outstanding IDs; later orphan responses set rsp_err per REQ-024.

Structure
REQ-030 Package rv_mem_pkg SHALL hold src_t (SRC_I=0, SRC_D=1), arb_state_t, SIZE_WORD=2'b10.
REQ-031 Order FIFO SHALL be sub-module rv_src_fifo (DEPTH x 1-bit, push/pop/count, async active-low reset).

Verification
REQ-032 Instr only, addr 0x100, ready=1, rsp 0x00000013 next cycle -> mem_req_addr=0x100 same cycle; instr_rsp_valid with 0x00000013.
REQ-033 Both valid every cycle, ready=1 -> grants D,I,D,I... (first D, last-grant reset I).
REQ-034 Data store addr 0x20, ready low 3 cycles, instr valid meanwhile -> mem_req fields stable 4 cycles, instr_req_ready 0 until store accepted.
REQ-035 DEPTH=2, accept I then D, no rsp -> third request ready 0; rsp 0xAA on cycle of third request -> it is accepted, instr_rsp_data=0xAA.
REQ-036 mem_rsp_valid with count 0 -> rsp_err 1 and no rsp_valid; reset_n pulse -> rsp_err 0.
REQ-037 Reset asserted with 2 outstanding -> count 0; next two responses set rsp_err, no upstream rsp_valid.
